cpu_mem_arbiter: RTL and testbench
==================================

// Module: cpu_mem_arbiter
// PURPOSE
//  Sits directly downstream of the multicycle RISC-V custom_cpu.
//  Merges its instruction channel and data channel onto one shared memory bus.
//  Accepts at most one request at a time, holds it stable on the bus, and routes the response back.
//  Also counts memory-busy cycles for a performance counter.
// PARAMETERS
//  ADDR_WIDTH  32  byte address width on both sides
//  DATA_WIDTH  32  data width; the strobe width is DATA_WIDTH/8
//  CNT_WIDTH   32  width of the busy-cycle counter
// PORTS
//  clk              in   1    single clock; everything is sampled on the rising edge
//  rst              in   1    synchronous, active-high reset
//  PC               in   AW   CPU instruction fetch address
//  Inst_Req_Valid   in   1    CPU instruction request valid
//  Inst_Req_Ready   out  1    instruction request accepted this cycle
//  Instruction      out  DW   fetched instruction word
//  Inst_Valid       out  1    Instruction is valid
//  Inst_Ready       in   1    CPU is ready to take the instruction
//  Address          in   AW   CPU data address, word aligned
//  MemWrite         in   1    CPU store request
//  Write_data       in   DW   store data
//  Write_strb       in   DW/8 store byte enables
//  MemRead          in   1    CPU load request
//  Mem_Req_Ready    out  1    data request accepted this cycle
//  Read_data        out  DW   load data
//  Read_data_Valid  out  1    Read_data is valid
//  Read_data_Ready  in   1    CPU is ready to take the load data
//  mem_req_valid    out  1    bus request valid
//  mem_req_ready    in   1    bus accepts the request
//  mem_req_addr     out  AW   bus address
//  mem_req_wen      out  1    1 = write, 0 = read
//  mem_req_wdata    out  DW   bus write data
//  mem_req_wstrb    out  DW/8 bus byte enables; all zero on reads
//  mem_resp_valid   in   1    bus read data valid
//  mem_resp_ready   out  1    arbiter can take the read data
//  mem_resp_data    in   DW   bus read data
//  busy_cycles      out  CW   saturating count of non-IDLE cycles
// BEHAVIOUR
//  States: IDLE, I_REQ, I_RESP, D_RD_REQ, D_RD_RESP, D_WR_REQ.
//  Reset: state = IDLE; busy_cycles = 0; request registers = 0; every valid/ready output = 0.
//  IDLE, data request pending (MemRead | MemWrite):
//   - Mem_Req_Ready = 1 and the request is captured.
//   - MemWrite -> D_WR_REQ; else -> D_RD_REQ.
//   - MemWrite and MemRead together: the write wins.
//  IDLE, instruction request only:
//   - Inst_Req_Ready = 1 only when Inst_Req_Valid & ~MemRead & ~MemWrite; data has priority.
//   - PC is captured with bits[1:0] forced to 0 -> I_REQ.
//  *_REQ states:
//   - mem_req_valid = 1; addr/wen/wdata/wstrb come only from the captured registers.
//   - These fields are stable until mem_req_ready.
//   - On mem_req_ready: I_REQ -> I_RESP; D_RD_REQ -> D_RD_RESP; D_WR_REQ -> IDLE (writes have no response).
//  I_RESP:
//   - Inst_Valid = mem_resp_valid; Instruction = mem_resp_data; mem_resp_ready = Inst_Ready.
//   - On mem_resp_valid & Inst_Ready -> IDLE.
//  D_RD_RESP: same as I_RESP, using Read_data_Valid, Read_data and Read_data_Ready.
//  Output gating:
//   - Inst_Valid and Read_data_Valid are 0 outside their RESP state.
//   - mem_resp_ready is 0 outside the RESP states.
//   - Instruction and Read_data are 0 outside their RESP state.
//  Latency: request accepted in cycle N -> mem_req_valid is high in cycle N+1. The response path is combinational pass-through.
//  Back-to-back: the earliest next acceptance is the cycle after returning to IDLE. There is no same-cycle re-acceptance.
//  busy_cycles:
//   - +1 every cycle state != IDLE.
//   - Holds at 2^CW-1 (saturates).
//   - Cleared only by rst.
//  Reset mid-operation:
//   - The transaction is abandoned and all valid/ready outputs drop the next cycle.
//   - The memory must be reset on the same rst.
//   - A late mem_resp_valid is never forwarded while in IDLE.
//  Protocol rules:
//   - Upstream valids may drop without a handshake; nothing is captured in that case.
//   - Downstream must not drop mem_resp_valid before the handshake.
// TESTING
//  1. Instruction fetch: PC=0x1006, mem_req_ready=1, response 0x00500093 after 3 cycles ->
//     mem_req_addr=0x1004, wen=0; Inst_Valid high for 1 cycle with Instruction=0x00500093; busy_cycles=5.
//  2. Store: Address=0x20, Write_data=0xAABBCCDD, strb=4'b0100, mem_req_ready held 0 for 4 cycles ->
//     bus fields stay constant through the stall; back to IDLE one cycle after ready; no response consumed.
//  3. Load with slow consumer: resp_valid with data 0x12345678 while Read_data_Ready=0 for 2 cycles ->
//     mem_resp_ready=0 and state stays D_RD_RESP; completes when ready rises.
//  4. Simultaneous Inst_Req_Valid and MemRead in IDLE -> Mem_Req_Ready=1 and Inst_Req_Ready=0;
//     the fetch is accepted only after the load completes.
//  5. rst asserted during I_RESP -> next cycle state=IDLE, mem_req_valid=0, Inst_Valid=0, busy_cycles=0.
//  6. Force busy_cycles to 0xFFFFFFFE, run 3 busy cycles -> value holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// Merges the CPU instruction and data request channels onto one shared memory bus.
// One transaction in flight at a time; a saturating counter tracks cycles spent outside IDLE.
module cpu_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  // instruction channel
  input  logic [ADDR_WIDTH-1:0]   PC,
  input  logic                    Inst_Req_Valid,
  output logic                    Inst_Req_Ready,
  output logic [DATA_WIDTH-1:0]   Instruction,
  output logic                    Inst_Valid,
  input  logic                    Inst_Ready,
  // data channel
  input  logic [ADDR_WIDTH-1:0]   Address,
  input  logic                    MemWrite,
  input  logic [DATA_WIDTH-1:0]   Write_data,
  input  logic [DATA_WIDTH/8-1:0] Write_strb,
  input  logic                    MemRead,
  output logic                    Mem_Req_Ready,
  output logic [DATA_WIDTH-1:0]   Read_data,
  output logic                    Read_data_Valid,
  input  logic                    Read_data_Ready,
  // shared memory bus
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic                    mem_req_wen,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
  input  logic                    mem_resp_valid,
  output logic                    mem_resp_ready,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data,
  // performance counter
  output logic [CNT_WIDTH-1:0]    busy_cycles
);

  localparam int StrbWidth = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_I_REQ,
    S_I_RESP,
    S_D_RD_REQ,
    S_D_RD_RESP,
    S_D_WR_REQ
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wen_q, wen_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [StrbWidth-1:0]    wstrb_q, wstrb_d;
  logic [CNT_WIDTH-1:0]    busy_q, busy_d;

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wen_d           = wen_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    Inst_Req_Ready  = 1'b0;
    Mem_Req_Ready   = 1'b0;
    mem_req_valid   = 1'b0;
    mem_resp_ready  = 1'b0;
    Inst_Valid      = 1'b0;
    Instruction     = '0;
    Read_data_Valid = 1'b0;
    Read_data       = '0;

    case (state_q)
      S_IDLE: begin
        // Data has priority over fetch; a simultaneous store and load issues the store.
        if (!rst) begin
          if (MemRead || MemWrite) begin
            Mem_Req_Ready = 1'b1;
            addr_d        = Address;
            wen_d         = MemWrite;
            wdata_d       = MemWrite ? Write_data : '0;
            wstrb_d       = MemWrite ? Write_strb : '0;
            state_d       = MemWrite ? S_D_WR_REQ : S_D_RD_REQ;
          end else if (Inst_Req_Valid) begin
            Inst_Req_Ready = 1'b1;
            addr_d         = {PC[ADDR_WIDTH-1:2], 2'b00};
            wen_d          = 1'b0;
            wdata_d        = '0;
            wstrb_d        = '0;
            state_d        = S_I_REQ;
          end
        end
      end

      S_I_REQ, S_D_RD_REQ, S_D_WR_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          case (state_q)
            S_I_REQ:    state_d = S_I_RESP;
            S_D_RD_REQ: state_d = S_D_RD_RESP;
            default:    state_d = S_IDLE;
          endcase
        end
      end

      S_I_RESP: begin
        Inst_Valid     = mem_resp_valid;
        Instruction    = mem_resp_data;
        mem_resp_ready = Inst_Ready;
        if (mem_resp_valid && Inst_Ready) state_d = S_IDLE;
      end

      S_D_RD_RESP: begin
        Read_data_Valid = mem_resp_valid;
        Read_data       = mem_resp_data;
        mem_resp_ready  = Read_data_Ready;
        if (mem_resp_valid && Read_data_Ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d = busy_q;
    if (state_q != S_IDLE && busy_q != {CNT_WIDTH{1'b1}}) busy_d = busy_q + CNT_WIDTH'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      busy_q  <= busy_d;
    end
  end

  // Bus fields come straight from the capture registers so they cannot move during a stall.
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;
  assign busy_cycles   = busy_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: directed scenarios plus a randomized run scored against
// a transaction-level model backed by a small word memory.
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC, Address, Write_data, mem_resp_data;
  logic [3:0]  Write_strb;
  logic        Inst_Req_Valid, Inst_Ready, MemWrite, MemRead, Read_data_Ready;
  logic        mem_req_ready, mem_resp_valid;

  logic        Inst_Req_Ready, Inst_Valid, Mem_Req_Ready, Read_data_Valid;
  logic [31:0] Instruction, Read_data;
  logic        mem_req_valid, mem_req_wen, mem_resp_ready;
  logic [31:0] mem_req_addr, mem_req_wdata, busy_cycles;
  logic [3:0]  mem_req_wstrb;

  logic        s_irr, s_iv, s_mrr, s_rdv, s_mrv, s_wen, s_rspr;
  logic [31:0] s_inst, s_rd, s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [2:0]  s_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
    .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
    .Address(Address), .MemWrite(MemWrite), .Write_data(Write_data), .Write_strb(Write_strb),
    .MemRead(MemRead), .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data),
    .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_data(mem_resp_data),
    .busy_cycles(busy_cycles)
  );

  // Narrow-counter copy so saturation is reachable in a few cycles.
  cpu_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(3)) dut_sat (
    .clk(clk), .rst(rst),
    .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(s_irr),
    .Instruction(s_inst), .Inst_Valid(s_iv), .Inst_Ready(Inst_Ready),
    .Address(Address), .MemWrite(MemWrite), .Write_data(Write_data), .Write_strb(Write_strb),
    .MemRead(MemRead), .Mem_Req_Ready(s_mrr), .Read_data(s_rd),
    .Read_data_Valid(s_rdv), .Read_data_Ready(Read_data_Ready),
    .mem_req_valid(s_mrv), .mem_req_ready(mem_req_ready), .mem_req_addr(s_addr),
    .mem_req_wen(s_wen), .mem_req_wdata(s_wdata), .mem_req_wstrb(s_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(s_rspr), .mem_resp_data(mem_resp_data),
    .busy_cycles(s_busy)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    PC = '0; Inst_Req_Valid = 0; Inst_Ready = 0;
    Address = '0; MemWrite = 0; Write_data = '0; Write_strb = '0; MemRead = 0; Read_data_Ready = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    MemRead = 1; Inst_Req_Valid = 1; mem_resp_valid = 1; Inst_Ready = 1; Read_data_Ready = 1;
    tick(); tick(); #1;
    checks++; if (Mem_Req_Ready !== 1'b0) begin errors++; $display("FAIL rst_mrr got %b want 0", Mem_Req_Ready); end
    checks++; if (Inst_Req_Ready !== 1'b0) begin errors++; $display("FAIL rst_irr got %b want 0", Inst_Req_Ready); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mv got %b want 0", mem_req_valid); end
    checks++; if (Inst_Valid !== 1'b0 || Read_data_Valid !== 1'b0) begin errors++; $display("FAIL rst_valids got %b%b want 00", Inst_Valid, Read_data_Valid); end
    checks++; if (mem_resp_ready !== 1'b0) begin errors++; $display("FAIL rst_rspr got %b want 0", mem_resp_ready); end
    checks++; if (busy_cycles !== 32'd0) begin errors++; $display("FAIL rst_busy got %0d want 0", busy_cycles); end
    checks++; if (mem_req_addr !== 32'd0 || mem_req_wstrb !== 4'd0 || mem_req_wen !== 1'b0) begin errors++; $display("FAIL rst_regs got %h/%h/%b want 0", mem_req_addr, mem_req_wstrb, mem_req_wen); end
    checks++; if (Instruction !== 32'd0 || Read_data !== 32'd0) begin errors++; $display("FAIL rst_data got %h/%h want 0", Instruction, Read_data); end
    idle_inputs();
    rst = 0;
    tick();
  endtask

  task automatic test_fetch();
    do_reset();
    PC = 32'h1006; Inst_Req_Valid = 1; mem_req_ready = 1; #1;
    checks++; if (Inst_Req_Ready !== 1'b1) begin errors++; $display("FAIL fetch_irr got %b want 1", Inst_Req_Ready); end
    checks++; if (Mem_Req_Ready !== 1'b0) begin errors++; $display("FAIL fetch_mrr got %b want 0", Mem_Req_Ready); end
    tick();
    Inst_Req_Valid = 0; PC = 32'hFFFF; #1;
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL fetch_mv got %b want 1", mem_req_valid); end
    checks++; if (mem_req_addr !== 32'h1004) begin errors++; $display("FAIL fetch_addr got %h want 00001004", mem_req_addr); end
    checks++; if (mem_req_wen !== 1'b0 || mem_req_wstrb !== 4'd0) begin errors++; $display("FAIL fetch_wen got %b/%h want 0/0", mem_req_wen, mem_req_wstrb); end
    tick();
    mem_req_ready = 0; Inst_Ready = 1;
    for (int i = 0; i < 3; i++) begin
      mem_resp_data = $urandom; #1;
      checks++; if (Inst_Valid !== 1'b0) begin errors++; $display("FAIL fetch_wait%0d got %b want 0", i, Inst_Valid); end
      tick();
    end
    mem_resp_valid = 1; mem_resp_data = 32'h00500093; #1;
    checks++; if (Inst_Valid !== 1'b1) begin errors++; $display("FAIL fetch_iv got %b want 1", Inst_Valid); end
    checks++; if (Instruction !== 32'h00500093) begin errors++; $display("FAIL fetch_inst got %h want 00500093", Instruction); end
    checks++; if (mem_resp_ready !== 1'b1) begin errors++; $display("FAIL fetch_rspr got %b want 1", mem_resp_ready); end
    tick();
    mem_resp_valid = 0; #1;
    checks++; if (Inst_Valid !== 1'b0 || Instruction !== 32'd0) begin errors++; $display("FAIL fetch_done got %b/%h want 0/0", Inst_Valid, Instruction); end
    checks++; if (busy_cycles !== 32'd5) begin errors++; $display("FAIL fetch_busy got %0d want 5", busy_cycles); end
  endtask

  task automatic test_store_stall();
    do_reset();
    Address = 32'h20; Write_data = 32'hAABBCCDD; Write_strb = 4'b0100; MemWrite = 1; #1;
    checks++; if (Mem_Req_Ready !== 1'b1) begin errors++; $display("FAIL st_mrr got %b want 1", Mem_Req_Ready); end
    tick();
    MemWrite = 0; Address = 32'h3C; Write_data = 32'h0; Write_strb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin mem_req_ready = 1; mem_resp_valid = 1; end
      #1;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h20 || mem_req_wen !== 1'b1 ||
          mem_req_wdata !== 32'hAABBCCDD || mem_req_wstrb !== 4'b0100) begin
        errors++;
        $display("FAIL st_hold%0d got v=%b a=%h w=%b d=%h s=%h want 1/20/1/aabbccdd/4",
                 i, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb);
      end
      tick();
    end
    mem_req_ready = 0; #1;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL st_idle got %b want 0", mem_req_valid); end
    checks++; if (mem_resp_ready !== 1'b0 || Read_data_Valid !== 1'b0) begin errors++; $display("FAIL st_noresp got %b/%b want 0/0", mem_resp_ready, Read_data_Valid); end
    checks++; if (busy_cycles !== 32'd5) begin errors++; $display("FAIL st_busy got %0d want 5", busy_cycles); end
    mem_resp_valid = 0;
  endtask

  task automatic test_load_slow();
    do_reset();
    MemRead = 1; Address = 32'h40; #1;
    checks++; if (Mem_Req_Ready !== 1'b1) begin errors++; $display("FAIL ld_mrr got %b want 1", Mem_Req_Ready); end
    tick();
    MemRead = 0; mem_req_ready = 1; #1;
    checks++; if (mem_req_addr !== 32'h40 || mem_req_wen !== 1'b0 || mem_req_wstrb !== 4'd0) begin errors++; $display("FAIL ld_req got %h/%b/%h want 40/0/0", mem_req_addr, mem_req_wen, mem_req_wstrb); end
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'h12345678; Read_data_Ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (Read_data_Valid !== 1'b1 || Read_data !== 32'h12345678 || mem_resp_ready !== 1'b0 ||
          mem_req_valid !== 1'b0 || Inst_Valid !== 1'b0) begin
        errors++;
        $display("FAIL ld_stall%0d got rv=%b rd=%h rr=%b mv=%b iv=%b want 1/12345678/0/0/0",
                 i, Read_data_Valid, Read_data, mem_resp_ready, mem_req_valid, Inst_Valid);
      end
      tick();
    end
    Read_data_Ready = 1; #1;
    checks++; if (Read_data_Valid !== 1'b1 || mem_resp_ready !== 1'b1) begin errors++; $display("FAIL ld_hs got %b/%b want 1/1", Read_data_Valid, mem_resp_ready); end
    tick();
    mem_resp_valid = 0; Read_data_Ready = 0; #1;
    checks++; if (Read_data_Valid !== 1'b0 || Read_data !== 32'd0) begin errors++; $display("FAIL ld_done got %b/%h want 0/0", Read_data_Valid, Read_data); end
    checks++; if (busy_cycles !== 32'd4) begin errors++; $display("FAIL ld_busy got %0d want 4", busy_cycles); end
  endtask

  task automatic test_priority();
    do_reset();
    Inst_Req_Valid = 1; PC = 32'h200; MemRead = 1; Address = 32'h80; #1;
    checks++; if (Mem_Req_Ready !== 1'b1 || Inst_Req_Ready !== 1'b0) begin errors++; $display("FAIL pri_accept got %b/%b want 1/0", Mem_Req_Ready, Inst_Req_Ready); end
    tick();
    MemRead = 0; mem_req_ready = 1; #1;
    checks++; if (Inst_Req_Ready !== 1'b0 || mem_req_addr !== 32'h80) begin errors++; $display("FAIL pri_req got %b/%h want 0/80", Inst_Req_Ready, mem_req_addr); end
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'hCAFE0001; Read_data_Ready = 1; #1;
    checks++; if (Inst_Req_Ready !== 1'b0 || Read_data_Valid !== 1'b1) begin errors++; $display("FAIL pri_resp got %b/%b want 0/1", Inst_Req_Ready, Read_data_Valid); end
    tick();
    mem_resp_valid = 0; #1;
    checks++; if (Inst_Req_Ready !== 1'b1 || Mem_Req_Ready !== 1'b0) begin errors++; $display("FAIL pri_fetch got %b/%b want 1/0", Inst_Req_Ready, Mem_Req_Ready); end
    tick();
    Inst_Req_Valid = 0; #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h200) begin errors++; $display("FAIL pri_fetchreq got %b/%h want 1/200", mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    Inst_Req_Valid = 1; PC = 32'h300; mem_req_ready = 1;
    tick();
    Inst_Req_Valid = 0;
    tick();
    mem_req_ready = 0; Inst_Ready = 1; #1;
    checks++; if (mem_resp_ready !== 1'b1) begin errors++; $display("FAIL rmid_inresp got %b want 1", mem_resp_ready); end
    rst = 1; Inst_Ready = 0; mem_resp_valid = 1; mem_resp_data = 32'h0BADF00D;
    tick();
    rst = 0; Inst_Ready = 1; #1;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rmid_mv got %b want 0", mem_req_valid); end
    checks++; if (Inst_Valid !== 1'b0 || Instruction !== 32'd0 || mem_resp_ready !== 1'b0) begin errors++; $display("FAIL rmid_late got %b/%h/%b want 0/0/0", Inst_Valid, Instruction, mem_resp_ready); end
    checks++; if (busy_cycles !== 32'd0) begin errors++; $display("FAIL rmid_busy got %0d want 0", busy_cycles); end
    tick(); #1;
    checks++; if (Inst_Valid !== 1'b0 || busy_cycles !== 32'd0) begin errors++; $display("FAIL rmid_stay got %b/%0d want 0/0", Inst_Valid, busy_cycles); end
    mem_resp_valid = 0; Inst_Ready = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    MemWrite = 1; Address = 32'h0; Write_strb = 4'hF;
    tick();
    MemWrite = 0; mem_req_ready = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++; if (s_busy !== 3'((i > 7) ? 7 : i)) begin errors++; $display("FAIL sat_%0d got %0d want %0d", i, s_busy, (i > 7) ? 7 : i); end
      checks++; if (busy_cycles !== 32'(i)) begin errors++; $display("FAIL sat_wide_%0d got %0d want %0d", i, busy_cycles, i); end
      tick();
    end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
  endtask

  typedef enum {OP_NONE, OP_FETCH, OP_LOAD, OP_STORE} op_e;

  task automatic test_random();
    logic [31:0] mem_m [0:63];
    op_e         op = OP_NONE;
    bit          issued = 0;
    bit          rv = 0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0]  m_wstrb = '0;
    logic [31:0] m_busy = '0;
    int          n_done = 0;
    for (int i = 0; i < 64; i++) mem_m[i] = $urandom;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit in_i, in_d, resp_phase, exp_mrr, exp_irr, exp_mv, exp_rr;
      logic [31:0] exp_inst, exp_rd;
      Inst_Req_Valid  = ($urandom % 3 == 0);
      MemRead         = ($urandom % 4 == 0);
      MemWrite        = ($urandom % 5 == 0);
      PC              = 32'($urandom_range(0, 255));
      Address         = 32'($urandom_range(0, 63)) << 2;
      Write_data      = $urandom;
      Write_strb      = 4'($urandom_range(0, 15));
      mem_req_ready   = ($urandom % 2 == 0);
      Inst_Ready      = ($urandom % 2 == 0);
      Read_data_Ready = ($urandom % 2 == 0);
      resp_phase = issued && (op == OP_FETCH || op == OP_LOAD);
      if (resp_phase) begin
        if (!rv) rv = ($urandom % 3 == 0);
      end else begin
        rv = ($urandom % 10 == 0);
      end
      mem_resp_valid = rv;
      mem_resp_data  = (resp_phase && rv) ? mem_m[m_addr[7:2]] : $urandom;
      #1;
      in_i     = issued && op == OP_FETCH;
      in_d     = issued && op == OP_LOAD;
      exp_mrr  = (op == OP_NONE) && (MemRead || MemWrite);
      exp_irr  = (op == OP_NONE) && Inst_Req_Valid && !MemRead && !MemWrite;
      exp_mv   = (op != OP_NONE) && !issued;
      exp_rr   = in_i ? Inst_Ready : (in_d ? Read_data_Ready : 1'b0);
      exp_inst = in_i ? mem_resp_data : 32'd0;
      exp_rd   = in_d ? mem_resp_data : 32'd0;
      if (in_i && rv) exp_inst = mem_m[m_addr[7:2]];
      if (in_d && rv) exp_rd   = mem_m[m_addr[7:2]];
      checks++;
      if (Mem_Req_Ready !== exp_mrr || Inst_Req_Ready !== exp_irr || mem_req_valid !== exp_mv || mem_resp_ready !== exp_rr) begin
        errors++;
        $display("FAIL rnd_hs c%0d got mrr=%b irr=%b mv=%b rr=%b want %b %b %b %b", cyc,
                 Mem_Req_Ready, Inst_Req_Ready, mem_req_valid, mem_resp_ready, exp_mrr, exp_irr, exp_mv, exp_rr);
      end
      checks++;
      if (Inst_Valid !== (in_i && rv) || Read_data_Valid !== (in_d && rv) || Instruction !== exp_inst || Read_data !== exp_rd) begin
        errors++;
        $display("FAIL rnd_resp c%0d got iv=%b rv=%b inst=%h rd=%h want %b %b %h %h", cyc,
                 Inst_Valid, Read_data_Valid, Instruction, Read_data, in_i && rv, in_d && rv, exp_inst, exp_rd);
      end
      if (exp_mv) begin
        checks++;
        if (mem_req_addr !== m_addr || mem_req_wen !== (op == OP_STORE) || mem_req_wstrb !== m_wstrb ||
            (op == OP_STORE && mem_req_wdata !== m_wdata)) begin
          errors++;
          $display("FAIL rnd_req c%0d got a=%h w=%b s=%h d=%h want %h %b %h %h", cyc,
                   mem_req_addr, mem_req_wen, mem_req_wstrb, mem_req_wdata, m_addr, op == OP_STORE, m_wstrb, m_wdata);
        end
      end
      checks++; if (busy_cycles !== m_busy) begin errors++; $display("FAIL rnd_busy c%0d got %0d want %0d", cyc, busy_cycles, m_busy); end
      if (op != OP_NONE) m_busy = m_busy + 1;
      if (op == OP_NONE) begin
        issued = 0;
        if (MemRead || MemWrite) begin
          op      = MemWrite ? OP_STORE : OP_LOAD;
          m_addr  = Address;
          m_wdata = Write_data;
          m_wstrb = MemWrite ? Write_strb : 4'd0;
        end else if (Inst_Req_Valid) begin
          op      = OP_FETCH;
          m_addr  = PC & ~32'd3;
          m_wstrb = 4'd0;
        end
      end else if (!issued) begin
        if (mem_req_ready) begin
          if (op == OP_STORE) begin
            for (int b = 0; b < 4; b++)
              if (m_wstrb[b]) mem_m[m_addr[7:2]][8*b +: 8] = m_wdata[8*b +: 8];
            op = OP_NONE;
            n_done++;
          end else begin
            issued = 1;
          end
        end
      end else if (rv && ((op == OP_FETCH) ? Inst_Ready : Read_data_Ready)) begin
        op = OP_NONE;
        issued = 0;
        rv = 0;
        n_done++;
      end
      tick();
    end
    checks++; if (n_done < 100) begin errors++; $display("FAIL rnd_progress got %0d want >=100", n_done); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch();
    test_store_stall();
    test_load_slow();
    test_priority();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
